block128_loader: RTL
====================

Name: block128_loader

Overview:
- Serial-to-parallel stage upstream of the 128-bit key/nonce/tag holding register in the ASCON datapath.
- Accepts WORD_W-bit words over a valid/ready handshake and packs them MSB-first into one 128-bit block.
- Presents the finished block with a valid/ready handshake. The consumer's register enable is block_valid_o AND block_ready_i.

Parameters:
- WORD_W, 32: input word width; legal values are 32 and 64 only.
- NB_WORDS, 128/WORD_W: words per block; derived, never overridden.

Ports:
- clock_i  input  1  system clock, rising edge
- resetb_i  input  1  asynchronous active-low reset
- clear_i  input  1  synchronous abort/flush; highest priority after reset
- word_valid_i  input  1  upstream word valid
- word_ready_o  output  1  loader can accept a word
- word_i  input  WORD_W  input word; first word lands in bits 127 down to 128-WORD_W
- block_valid_o  output  1  data_o holds a complete block
- block_ready_i  input  1  downstream accepts block this cycle
- data_o  output  128  assembled block
- count_o  output  3  number of words accepted into the current block (0..NB_WORDS)

Behaviour:
- Reset (resetb_i low, asynchronous):
  - state goes to FILL, count_o=0, data_o=0, block_valid_o=0.
  - word_ready_o=1 as soon as reset is released.
- State FILL:
  - word_ready_o=1, block_valid_o=0.
  - On word_valid_i AND word_ready_o, word_i is written to slot count_o. Slot k occupies bits 127-k*WORD_W down to 128-(k+1)*WORD_W.
  - After each accepted word, count_o increments.
  - Other slots hold their value. Slots not yet written in the current block read as 0.
- FILL to FULL:
  - Occurs on the clock edge that accepts word NB_WORDS-1; count_o becomes NB_WORDS.
  - block_valid_o is high the cycle after the last word is accepted; latency is 1 cycle.
- State FULL:
  - word_ready_o=0, block_valid_o=1, data_o stable.
  - word_valid_i is ignored; the upstream holds its word.
- FULL to FILL:
  - Occurs on a cycle where block_ready_i=1.
  - Next cycle: count_o=0, data_o=0, block_valid_o=0, word_ready_o=1.
  - No word can be accepted in the same cycle as the block handoff, so no bypass path exists.
- block_ready_i in FILL has no effect.
- clear_i=1, any state: next cycle is FILL, count_o=0, data_o=0, block_valid_o=0.
  - A word presented in that cycle is discarded, even if word_ready_o=1.
  - A pending block is dropped, even if block_ready_i=1.
- Reset mid-block: partial data is lost and the loader restarts at slot 0.
- count_o never exceeds NB_WORDS and never wraps within a block.
- All outputs are registered except word_ready_o, which is decoded from the state register only. There is no combinational path from any input to any output.

Optional Feature:
- Macro: BLOCK128_LOADER_BYTE_SWAP_EN.
- Defined: each accepted word is byte-reversed before storage (byte 0 of word_i goes to the MSB byte of its slot). Used for little-endian bus masters.
- Not defined: words are stored unmodified.
- Handshake and timing are identical in both builds.

Decomposition:
- Add to the shared package ascon_pack:
  - loader_state_t enum {FILL, FULL};
  - constant BLOCK_W=128;
  - a byte-reverse function, parameterised on width, for the optional feature.
- Implement as a single module with no sub-module: one FSM/counter process and one data-register process.

Test Plan:
- Reset with WORD_W=32:
  - Assert resetb_i mid-operation → data_o=0, block_valid_o=0, count_o=0 immediately (asynchronous).
  - After release, word_ready_o=1.
- Back-to-back fill:
  - Send 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with valid held high.
  - Expect count_o=1,2,3,4.
  - block_valid_o goes high the cycle after word 4, with data_o=0x00112233_44556677_8899AABB_CCDDEEFF.
- Backpressure:
  - Hold block_ready_i=0 for 5 cycles with word_valid_i=1 → word_ready_o=0 and data_o unchanged.
  - Raise block_ready_i for 1 cycle → next cycle count_o=0, word_ready_o=1.
- Gapped input: insert idle cycles between words and toggle block_ready_i during FILL → same block as above, no spurious block_valid_o.
- Clear:
  - Pulse clear_i after 2 words with valid high → next cycle count_o=0 and data_o=0; the presented word is not stored.
  - Pulse clear_i in FULL while block_ready_i=1 → block dropped, FILL state.
- WORD_W=64 with the macro defined:
  - Send 0x0706050403020100, then 0x0F0E0D0C0B0A0908.
  - Expect data_o=0x0001020304050607_08090A0B0C0D0E0F and block_valid_o high after 2 words.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared ASCON datapath package: loader state encoding, block width and
// a byte-reverse helper used by the optional little-endian word path.
package ascon_pack;

  localparam int BLOCK_W = 128;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_t;

  // Reverse the order of the low nbytes bytes of w (nbytes <= 8).
  // The result is right-aligned, so callers truncate to their own width.
  function automatic logic [63:0] byte_rev(input logic [63:0] w,
                                           input int unsigned nbytes);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbytes) r[8*(nbytes-1-i) +: 8] = w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/block128_loader.sv
// block128_loader: packs WORD_W-bit words (32 or 64), MSB-first, into one
// 128-bit block and hands it downstream over a valid/ready handshake.
// Optional build macro: BLOCK128_LOADER_BYTE_SWAP_EN byte-reverses every
// accepted word before storage (little-endian bus masters).
module block128_loader
  import ascon_pack::*;
#(
  parameter  int WORD_W   = 32,
  localparam int NB_WORDS = BLOCK_W / WORD_W
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               clear_i,
  input  logic               word_valid_i,
  output logic               word_ready_o,
  input  logic [WORD_W-1:0]  word_i,
  output logic               block_valid_o,
  input  logic               block_ready_i,
  output logic [BLOCK_W-1:0] data_o,
  output logic [2:0]         count_o
);

  localparam logic [2:0] LAST_SLOT = 3'(NB_WORDS - 1);

  loader_state_t      state_q, state_d;
  logic [2:0]         count_q, count_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [WORD_W-1:0]  word_st;
  logic               accept;
  logic               handoff;

  // Word as it will be stored in its slot.
`ifdef BLOCK128_LOADER_BYTE_SWAP_EN
  assign word_st = WORD_W'(byte_rev(64'(word_i), WORD_W / 8));
`else
  assign word_st = word_i;
`endif

  assign accept  = (state_q == FILL) && word_valid_i;
  assign handoff = (state_q == FULL) && block_ready_i;

  // State and word counter registers.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= FILL;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: clear beats everything; the last accepted word moves to FULL,
  // the downstream handshake returns to an empty FILL.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clear_i) begin
      state_d = FILL;
      count_d = 3'd0;
    end else if (accept) begin
      count_d = count_q + 3'd1;
      if (count_q == LAST_SLOT) state_d = FULL;
    end else if (handoff) begin
      state_d = FILL;
      count_d = 3'd0;
    end
  end

  // Outputs decoded from the state register only.
  always_comb begin
    word_ready_o  = (state_q == FILL);
    block_valid_o = (state_q == FULL);
  end

  // Block data next value: zero on clear/handoff so unwritten slots read 0.
  always_comb begin
    data_d = data_q;
    if (clear_i || handoff) begin
      data_d = '0;
    end else if (accept) begin
      data_d[BLOCK_W-1-int'(count_q)*WORD_W -: WORD_W] = word_st;
    end
  end

  // Block data register.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) data_q <= '0;
    else           data_q <= data_d;
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule
